// File: rtl/mem_data_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The lock counter width is derived from the maximum idle-owner count.
package mem_data_pkg;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 32;
  localparam int MAX_LOCK_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  function automatic int lock_cnt_w(input int max_lock);
    return $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin picker: on a tie the port not served last wins.
// Purely combinational; pick_o is one-hot or zero.
module mem_arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  // last_i = 1 means port 1 was served last, so port 0 wins a tie.
  assign pick_o[0] = req_i[0] & (~req_i[1] | last_i);
  assign pick_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/mem_data_arb.sv
// Shares the single data-memory port between the CPU (port 0) and the DMA loader (port 1),
// with round-robin arbitration, ownership lock for RMW sequences and a lock timeout.
module mem_data_arb
  import mem_data_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_wr,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_wr,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          lock_timeout,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LCW = lock_cnt_w(MAX_LOCK);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

  arb_state_e     state_q;
  logic           last_q;
  logic [LCW-1:0] lock_cnt_q;
  logic           lock_timeout_q;
  logic [1:0]     rvalid_q;
  logic [DW-1:0]  rdata0_q;
  logic [DW-1:0]  rdata1_q;

  logic [1:0] req;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic [1:0] xfer;

  assign req = {r1_req, r0_req};

  mem_arb_rr2 u_rr2 (
    .req_i  (req),
    .last_i (last_q),
    .pick_o (pick)
  );

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      unique case (state_q)
        IDLE:    gnt = pick;
        OWN0:    gnt = {1'b0, r0_req};
        OWN1:    gnt = {r1_req, 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign xfer   = req & gnt;
  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  // Port 0 drives the memory pins whenever port 1 is not granted.
  assign mem_addr  = gnt[1] ? r1_addr  : r0_addr;
  assign mem_wdata = gnt[1] ? r1_wdata : r0_wdata;
  assign mem_wr    = (xfer[0] & r0_wr) | (xfer[1] & r1_wr);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      lock_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      lock_timeout_q <= 1'b0;
      if (xfer[0]) begin
        last_q     <= 1'b0;
        lock_cnt_q <= '0;
        state_q    <= r0_lock ? OWN0 : IDLE;
      end else if (xfer[1]) begin
        last_q     <= 1'b1;
        lock_cnt_q <= '0;
        state_q    <= r1_lock ? OWN1 : IDLE;
      end else if (state_q != IDLE) begin
        if (lock_cnt_q == LOCK_LAST) begin
          // Forced release: the stale owner counts as last served so the other port wins next.
          state_q        <= IDLE;
          last_q         <= (state_q == OWN1);
          lock_cnt_q     <= '0;
          lock_timeout_q <= 1'b1;
        end else begin
          lock_cnt_q <= lock_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= xfer;
      if (xfer[0] && !r0_wr) rdata0_q <= mem_rdata;
      if (xfer[1] && !r1_wr) rdata1_q <= mem_rdata;
    end
  end

  assign r0_rvalid    = rvalid_q[0];
  assign r1_rvalid    = rvalid_q[1];
  assign r0_rdata     = rdata0_q;
  assign r1_rdata     = rdata1_q;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_mem_data_arb.sv
// Directed bench for mem_data_arb with a 256 x 32 memory model on the memory pins.
// Inputs change 1 time unit after posedge; outputs are sampled before the next edge.
module tb_mem_data_arb;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MAX_LOCK = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_wr, r0_lock;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt, r0_rvalid;
  logic [DW-1:0] r0_rdata;
  logic          r1_req, r1_wr, r1_lock;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt, r1_rvalid;
  logic [DW-1:0] r1_rdata;
  logic          lock_timeout;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  mem_data_arb #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_req       (r0_req),
    .r0_wr        (r0_wr),
    .r0_lock      (r0_lock),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r0_gnt       (r0_gnt),
    .r0_rvalid    (r0_rvalid),
    .r0_rdata     (r0_rdata),
    .r1_req       (r1_req),
    .r1_wr        (r1_wr),
    .r1_lock      (r1_lock),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .r1_gnt       (r1_gnt),
    .r1_rvalid    (r1_rvalid),
    .r1_rdata     (r1_rdata),
    .lock_timeout (lock_timeout),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic wr, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    r0_req = req; r0_wr = wr; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    r1_req = req; r1_wr = wr; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int cnt0, cnt1, to_cnt;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'd5;
    rst_n = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, 1'b0, '0, '0);

    // Reset state
    step(); step();
    check("rst_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    check("rst_r0_rdata", r0_rdata, 32'd0);
    check("rst_timeout", {31'b0, lock_timeout}, 32'd0);
    drive0(1'b1, 1'b0, 1'b0, 8'h01, '0);
    settle();
    check("rst_gnt_blocked", {31'b0, r0_gnt}, 32'd0);
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    step();

    // Write then read back through the other port
    drive0(1'b1, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
    settle();
    check("wr_r0_gnt", {31'b0, r0_gnt}, 32'd1);
    check("wr_mem_wr", {31'b0, mem_wr}, 32'd1);
    check("wr_mem_addr", {24'b0, mem_addr}, 32'h10);
    step();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 1'b0, 8'h10, '0);
    settle();
    check("wr_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
    check("rd_mem_wr_low", {31'b0, mem_wr}, 32'd0);
    check("rd_r1_gnt", {31'b0, r1_gnt}, 32'd1);
    step();
    drive1(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    check("rd_r1_rvalid", {31'b0, r1_rvalid}, 32'd1);
    check("rd_r1_rdata", r1_rdata, 32'hDEADBEEF);
    check("rd_r0_rvalid_low", {31'b0, r0_rvalid}, 32'd0);

    // Round-robin tie: last served was port 1, so port 0 goes first
    cnt0 = 0; cnt1 = 0;
    drive0(1'b1, 1'b0, 1'b0, 8'h10, '0);
    drive1(1'b1, 1'b0, 1'b0, 8'h10, '0);
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("rr_r0_gnt_%0d", i), {31'b0, r0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_r1_gnt_%0d", i), {31'b0, r1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      cnt0 += int'(r0_rvalid);
      cnt1 += int'(r1_rvalid);
    end
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, 1'b0, '0, '0);
    check("rr_r0_pulses", cnt0, 32'd3);
    check("rr_r1_pulses", cnt1, 32'd3);
    step();

    // Locked read-modify-write by port 0 while port 1 waits
    drive0(1'b1, 1'b0, 1'b1, 8'h20, '0);
    drive1(1'b1, 1'b0, 1'b0, 8'h20, '0);
    settle();
    check("lk_r0_gnt", {31'b0, r0_gnt}, 32'd1);
    check("lk_r1_gnt", {31'b0, r1_gnt}, 32'd0);
    step();
    check("lk_r0_rdata", r0_rdata, 32'd5);
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    check("lk_r1_blocked_idle", {31'b0, r1_gnt}, 32'd0);
    step();
    drive0(1'b1, 1'b1, 1'b0, 8'h20, 32'd6);
    settle();
    check("lk_r1_blocked_wr", {31'b0, r1_gnt}, 32'd0);
    check("lk_r0_wr_gnt", {31'b0, r0_gnt}, 32'd1);
    step();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    check("lk_r1_gnt_after", {31'b0, r1_gnt}, 32'd1);
    step();
    drive1(1'b0, 1'b0, 1'b0, '0, '0);
    check("lk_r1_rdata", r1_rdata, 32'd6);
    step();

    // Lock timeout: owner idle for MAX_LOCK cycles, other port granted on cycle MAX_LOCK+1
    drive0(1'b1, 1'b0, 1'b1, 8'h10, '0);
    step();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 1'b0, 8'h20, '0);
    to_cnt = 0;
    for (int k = 1; k <= MAX_LOCK + 1; k++) begin
      settle();
      to_cnt += int'(lock_timeout);
      if (k <= MAX_LOCK) check($sformatf("to_r1_blocked_%0d", k), {31'b0, r1_gnt}, 32'd0);
      else               check("to_r1_gnt", {31'b0, r1_gnt}, 32'd1);
      step();
    end
    drive1(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    to_cnt += int'(lock_timeout);
    check("to_pulse_count", to_cnt, 32'd1);
    step();

    // Owner transfer on the would-be timeout cycle wins
    drive0(1'b1, 1'b0, 1'b1, 8'h10, '0);
    step();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 1'b0, 8'h20, '0);
    for (int k = 1; k < MAX_LOCK; k++) step();
    drive0(1'b1, 1'b0, 1'b0, 8'h10, '0);
    settle();
    check("to_race_r0_gnt", {31'b0, r0_gnt}, 32'd1);
    step();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    check("to_race_no_timeout", {31'b0, lock_timeout}, 32'd0);
    check("to_race_r1_gnt", {31'b0, r1_gnt}, 32'd1);
    step();
    drive1(1'b0, 1'b0, 1'b0, '0, '0);
    step();

    // Reset asserted in the middle of a write
    drive0(1'b1, 1'b1, 1'b0, 8'h30, 32'h12345678);
    settle();
    check("mid_mem_wr_pre", {31'b0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    settle();
    check("mid_mem_wr_rst", {31'b0, mem_wr}, 32'd0);
    check("mid_r0_gnt_rst", {31'b0, r0_gnt}, 32'd0);
    step();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    step();
    check("mid_mem_unchanged", mem[8'h30], 32'd0);
    check("mid_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);

    // Write -1 then read it back on the next cycle
    drive0(1'b1, 1'b1, 1'b0, 8'h05, 32'hFFFFFFFF);
    step();
    drive0(1'b1, 1'b0, 1'b0, 8'h05, '0);
    settle();
    check("raw_wr_rvalid", {31'b0, r0_rvalid}, 32'd1);
    check("raw_wr_rdata_hold", r0_rdata, 32'd0);
    step();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    check("raw_rd_rvalid", {31'b0, r0_rvalid}, 32'd1);
    check("raw_rd_rdata", r0_rdata, 32'hFFFFFFFF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
